// File: rtl/bus_master_pkg.sv
// rtl/bus_master_pkg.sv - shared types and constants for the peripheral bus master
package bus_master_pkg;

  localparam int BUS_W  = 16;
  localparam int ADDR_W = 32;

  localparam logic [BUS_W-1:0] TIMEOUT_DATA = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    TURN  = 2'd3
  } state_t;

endpackage

// File: rtl/bus_master_tristate.sv
// rtl/bus_master_tristate.sv - tristate driver for a shared bidirectional bus
module triState #(
  parameter int W = 16
) (
  inout  wire  [W-1:0] bus,
  input  logic [W-1:0] data,
  input  logic         en
);

  assign bus = en ? data : {W{1'bz}};

endmodule

// File: rtl/bus_master.sv
// rtl/bus_master.sv - single-request initiator for the shared memory-mapped peripheral bus
module bus_master
  import bus_master_pkg::*;
#(
  parameter int                TIMEOUT      = 16,
  parameter int                WRITE_CYCLES = 1,
  parameter logic [ADDR_W-1:0] IDLE_ADDR    = 32'hFFFF_FFFF
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [BUS_W-1:0]  req_wdata,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [BUS_W-1:0]  resp_rdata,
  output logic              resp_timeout,
  inout  wire  [BUS_W-1:0]  BUS,
  output logic [ADDR_W-1:0] address,
  output logic              writeEn,
  output logic              outputEn,
  input  logic              readDone
);

  localparam int CNT_MAX = (TIMEOUT > WRITE_CYCLES) ? TIMEOUT : WRITE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t              r_state;
  state_t              w_next;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_next;
  logic [CNT_W-1:0]    w_cnt_inc;
  logic [ADDR_W-1:0]   r_addr;
  logic [BUS_W-1:0]    r_wdata;
  logic [ADDR_W-1:0]   r_address;
  logic [ADDR_W-1:0]   w_xfer_addr;
  logic                r_write_en;
  logic                r_output_en;
  logic                r_resp_valid;
  logic                r_resp_timeout;
  logic [BUS_W-1:0]    r_resp_rdata;
  logic                w_read_done;
  logic                w_capture;
  logic                w_timeout;
  logic                w_bus_en;

  // readDone floats on unselected peripherals; only a solid 1 completes a read
  assign w_read_done = (readDone == 1'b1);
  assign w_cnt_inc   = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);
  assign w_xfer_addr = (r_state == IDLE) ? req_addr : r_addr;
  assign w_bus_en    = (r_state == WRITE);

  always_comb begin
    w_next     = r_state;
    w_cnt_next = '0;
    w_capture  = 1'b0;
    w_timeout  = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          w_next = req_write ? WRITE : READ;
        end
      end
      WRITE: begin
        if (w_cnt_inc >= CNT_W'(WRITE_CYCLES)) begin
          w_next = TURN;
        end else begin
          w_cnt_next = w_cnt_inc;
        end
      end
      READ: begin
        if (w_read_done) begin
          w_next    = TURN;
          w_capture = 1'b1;
        end else if (w_cnt_inc >= CNT_W'(TIMEOUT)) begin
          w_next    = TURN;
          w_timeout = 1'b1;
        end else begin
          w_cnt_next = w_cnt_inc;
        end
      end
      TURN: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state        <= IDLE;
      r_cnt          <= '0;
      r_addr         <= '0;
      r_wdata        <= '0;
      r_address      <= IDLE_ADDR;
      r_write_en     <= 1'b0;
      r_output_en    <= 1'b0;
      r_resp_valid   <= 1'b0;
      r_resp_timeout <= 1'b0;
      r_resp_rdata   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (r_state == IDLE && req_valid) begin
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
      end
      // Bus outputs are loaded from the next state so they line up with it exactly
      r_address    <= (w_next == WRITE || w_next == READ) ? w_xfer_addr : IDLE_ADDR;
      r_write_en   <= (w_next == WRITE);
      r_output_en  <= (w_next == READ);
      r_resp_valid <= (w_next == TURN);
      if (w_capture) begin
        r_resp_rdata   <= BUS;
        r_resp_timeout <= 1'b0;
      end else if (w_timeout) begin
        r_resp_rdata   <= TIMEOUT_DATA;
        r_resp_timeout <= 1'b1;
      end else if (r_state == WRITE && w_next == TURN) begin
        r_resp_timeout <= 1'b0;
      end
    end
  end

  triState #(.W(BUS_W)) u_bus_drv (
    .bus  (BUS),
    .data (r_wdata),
    .en   (w_bus_en)
  );

  assign req_ready    = (r_state == IDLE);
  assign resp_valid   = r_resp_valid;
  assign resp_rdata   = r_resp_rdata;
  assign resp_timeout = r_resp_timeout;
  assign address      = r_address;
  assign writeEn      = r_write_en;
  assign outputEn     = r_output_en;

endmodule
